nec_ir_receiver: RTL

Decodes the demodulated IR remote signal from the board's IR receiver pin into 32-bit NEC codes. It is the producer of the `ir_in` code word consumed by the display and game-control logic, where codes such as 32'h20DF_5BA4 are compared directly. It measures mark and space widths against a 10 µs timebase and walks a frame state machine. It reports a held code, a one-cycle valid strobe, a repeat strobe and an error strobe.

---
 rtl/nec_ir_receiver.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/nec_ir_receiver.sv
// NEC IR remote decoder: turns the demodulated receiver pin into 32-bit codes with valid/repeat/error strobes.
// Define NEC_CHECK_EN to accept a frame only when its address and command bytes match their complements.
module nec_ir_receiver #(
  parameter int CLK_HZ   = 74_250_000,
  parameter int TICK_DIV = CLK_HZ / 100_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ir_rx_in,
  output logic [31:0] code_out,
  output logic        valid_out,
  output logic        repeat_out,
  output logic        error_out
);

  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  localparam logic [10:0] CNT_MAX       = 11'd2047;
  localparam logic [10:0] TIMEOUT_TICKS = 11'd1200;
  localparam logic [10:0] LEAD_MARK_MIN = 11'd800;
  localparam logic [10:0] LEAD_MARK_MAX = 11'd1000;
  localparam logic [10:0] DATA_SP_MIN   = 11'd400;
  localparam logic [10:0] DATA_SP_MAX   = 11'd500;
  localparam logic [10:0] RPT_SP_MIN    = 11'd180;
  localparam logic [10:0] RPT_SP_MAX    = 11'd270;
  localparam logic [10:0] BIT_MARK_MIN  = 11'd40;
  localparam logic [10:0] BIT_MARK_MAX  = 11'd75;
  localparam logic [10:0] ZERO_SP_MIN   = 11'd40;
  localparam logic [10:0] ZERO_SP_MAX   = 11'd80;
  localparam logic [10:0] ONE_SP_MIN    = 11'd140;
  localparam logic [10:0] ONE_SP_MAX    = 11'd200;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_RPT_MARK
  } state_t;

  function automatic logic in_win(input logic [10:0] v, input logic [10:0] lo,
                                  input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // sync_q[1:0] is the synchronizer; sync_q[2] holds the previous settled level for edge detection.
  logic [2:0] sync_q;
  logic       ir_edge, ir_rise, ir_fall;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], ir_rx_in};
  end

  assign ir_edge = sync_q[1] ^ sync_q[2];
  assign ir_rise = ir_edge & sync_q[1];
  assign ir_fall = ir_edge & ~sync_q[1];

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [10:0]   interval;

  assign tick = (pre_cnt == PRE_LAST);

  // The prescaler free-runs; only the interval counter is re-aligned on edges.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pre_cnt  <= '0;
      interval <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (ir_edge)                          interval <= '0;
      else if (tick && interval != CNT_MAX) interval <= interval + 11'd1;
    end
  end

  logic lead_mark_ok, data_sp_ok, rpt_sp_ok, bit_mark_ok, zero_sp_ok, one_sp_ok;

  assign lead_mark_ok = in_win(interval, LEAD_MARK_MIN, LEAD_MARK_MAX);
  assign data_sp_ok   = in_win(interval, DATA_SP_MIN, DATA_SP_MAX);
  assign rpt_sp_ok    = in_win(interval, RPT_SP_MIN, RPT_SP_MAX);
  assign bit_mark_ok  = in_win(interval, BIT_MARK_MIN, BIT_MARK_MAX);
  assign zero_sp_ok   = in_win(interval, ZERO_SP_MIN, ZERO_SP_MAX);
  assign one_sp_ok    = in_win(interval, ONE_SP_MIN, ONE_SP_MAX);

  state_t      state, state_nxt;
  logic [31:0] shift_q, shift_nxt, shift_in;
  logic [5:0]  bit_cnt, bit_cnt_nxt;
  logic        have_code, have_code_nxt;
  logic [31:0] code_nxt;
  logic        valid_nxt, repeat_nxt, error_nxt;
  logic        frame_ok, fail;

  assign shift_in = {shift_q[30:0], one_sp_ok};

`ifdef NEC_CHECK_EN
  assign frame_ok = (shift_in[31:24] == ~shift_in[23:16]) && (shift_in[15:8] == ~shift_in[7:0]);
`else
  assign frame_ok = 1'b1;
`endif

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    shift_nxt     = shift_q;
    bit_cnt_nxt   = bit_cnt;
    have_code_nxt = have_code;
    code_nxt      = code_out;
    valid_nxt     = 1'b0;
    repeat_nxt    = 1'b0;
    error_nxt     = 1'b0;
    fail          = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (ir_fall) state_nxt = S_LEAD_MARK;
      end
      S_LEAD_MARK: begin
        if (ir_edge) begin
          if (ir_rise && lead_mark_ok) state_nxt = S_LEAD_SPACE;
          else                         fail      = 1'b1;
        end
      end
      S_LEAD_SPACE: begin
        if (ir_edge) begin
          if (ir_fall && data_sp_ok) begin
            state_nxt   = S_BIT_MARK;
            bit_cnt_nxt = '0;
            shift_nxt   = '0;
          end else if (ir_fall && rpt_sp_ok) begin
            state_nxt  = S_RPT_MARK;
            repeat_nxt = have_code;
          end else begin
            fail = 1'b1;
          end
        end
      end
      S_BIT_MARK: begin
        if (ir_edge) begin
          if (ir_rise && bit_mark_ok) state_nxt = S_BIT_SPACE;
          else                        fail      = 1'b1;
        end
      end
      S_BIT_SPACE: begin
        if (ir_edge) begin
          if (ir_fall && (zero_sp_ok || one_sp_ok)) begin
            shift_nxt   = shift_in;
            bit_cnt_nxt = bit_cnt + 6'd1;
            if (bit_cnt == 6'd31) begin
              if (frame_ok) begin
                state_nxt     = S_STOP_MARK;
                code_nxt      = shift_in;
                valid_nxt     = 1'b1;
                have_code_nxt = 1'b1;
              end else begin
                fail = 1'b1;
              end
            end else begin
              state_nxt = S_BIT_MARK;
            end
          end else begin
            fail = 1'b1;
          end
        end
      end
      S_STOP_MARK, S_RPT_MARK: begin
        if (ir_rise) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Covers both malformed intervals and a line that stopped toggling mid-frame.
    if (state != S_IDLE && interval >= TIMEOUT_TICKS) fail = 1'b1;

    if (fail) begin
      state_nxt     = S_IDLE;
      shift_nxt     = '0;
      bit_cnt_nxt   = '0;
      code_nxt      = code_out;
      have_code_nxt = have_code;
      valid_nxt     = 1'b0;
      repeat_nxt    = 1'b0;
      error_nxt     = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= S_IDLE;
      shift_q    <= '0;
      bit_cnt    <= '0;
      have_code  <= 1'b0;
      code_out   <= '0;
      valid_out  <= 1'b0;
      repeat_out <= 1'b0;
      error_out  <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_q    <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      have_code  <= have_code_nxt;
      code_out   <= code_nxt;
      valid_out  <= valid_nxt;
      repeat_out <= repeat_nxt;
      error_out  <= error_nxt;
    end
  end

endmodule
